// File: rtl/uart_fetch_engine.sv
// Instruction-fetch engine: sends an optional header plus the fetch address over UART TX,
// then assembles the instruction from RX bytes, with a per-byte timeout and bounded retry.
module uart_fetch_engine #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned HDR_EN    = 1,
    parameter logic [7:0]  HDR_BYTE  = 8'h03,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [ADDR_W-1:0]    fetch_addr,
    input  logic                 hold,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 busy,
    output logic [INSTR_W-1:0]   instr_out,
    output logic                 instr_valid,
    output logic                 fetch_err,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    input  logic                 rx_done,
    input  logic [7:0]           rx_data
);

    localparam int unsigned ADDR_BYTES  = (ADDR_W + 7) / 8;
    localparam int unsigned INSTR_BYTES = (INSTR_W + 7) / 8;
    localparam int unsigned ADDR_PAD    = ADDR_BYTES * 8;
    localparam int unsigned ASM_W       = INSTR_BYTES * 8;
    localparam int unsigned HDR_OFS     = (HDR_EN != 0) ? 1 : 0;
    localparam int unsigned TX_BYTES    = ADDR_BYTES + HDR_OFS;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RECV, DONE, ERR} state_t;

    state_t               state, state_d;
    logic [ADDR_PAD-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0]     byte_idx, byte_idx_d;
    logic [IDX_W-1:0]     rx_cnt, rx_cnt_d;
    logic [RETRY_W-1:0]   retry, retry_d;
    logic [TIMEOUT_W-1:0] to_cnt, to_cnt_d;
    logic [ASM_W-1:0]     asm_q, asm_d;
    logic [INSTR_W-1:0]   instr_d;
    logic [7:0]           tx_data_d;
    logic                 timeout_hit;

    // Byte order on the wire: header (optional), then address bytes MSB first.
    function automatic logic [7:0] tx_byte(input logic [IDX_W-1:0] idx,
                                           input logic [ADDR_PAD-1:0] a);
        logic [7:0] b;
        b = 8'h00;
        if (HDR_EN != 0 && idx == '0) b = HDR_BYTE;
        for (int unsigned k = 0; k < ADDR_BYTES; k++) begin
            if (32'(idx) == k + HDR_OFS) b = a[(ADDR_BYTES-1-k)*8 +: 8];
        end
        return b;
    endfunction

    assign timeout_hit = (timeout_cycles != '0) && (to_cnt >= timeout_cycles);

    // Next-state and datapath update; a received byte takes priority over a timeout.
    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        byte_idx_d = byte_idx;
        rx_cnt_d   = rx_cnt;
        retry_d    = retry;
        to_cnt_d   = to_cnt;
        asm_d      = asm_q;
        instr_d    = instr_out;
        tx_data_d  = tx_data;
        case (state)
            IDLE: begin
                if (fetch_req && !hold) begin
                    addr_d     = ADDR_PAD'(fetch_addr);
                    retry_d    = '0;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: state_d = WAIT_TX;
            WAIT_TX: begin
                if (tx_done) begin
                    if (32'(byte_idx) + 32'd1 < TX_BYTES) begin
                        byte_idx_d = byte_idx + 1'b1;
                        state_d    = SEND;
                    end else begin
                        rx_cnt_d = '0;
                        to_cnt_d = '0;
                        asm_d    = '0;
                        state_d  = RECV;
                    end
                end
            end
            RECV: begin
                if (rx_done) begin
                    asm_d    = ASM_W'({asm_q, rx_data});
                    to_cnt_d = '0;
                    rx_cnt_d = rx_cnt + 1'b1;
                    if (32'(rx_cnt) + 32'd1 == INSTR_BYTES) begin
                        instr_d = INSTR_W'(asm_d);
                        state_d = DONE;
                    end
                end else if (timeout_hit) begin
                    if (32'(retry) < MAX_RETRY) begin
                        retry_d    = retry + 1'b1;
                        byte_idx_d = '0;
                        rx_cnt_d   = '0;
                        asm_d      = '0;
                        state_d    = SEND;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == SEND) tx_data_d = tx_byte(byte_idx_d, addr_d);
    end

    // State register and registered outputs, derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            byte_idx    <= '0;
            rx_cnt      <= '0;
            retry       <= '0;
            to_cnt      <= '0;
            asm_q       <= '0;
            busy        <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            byte_idx    <= byte_idx_d;
            rx_cnt      <= rx_cnt_d;
            retry       <= retry_d;
            to_cnt      <= to_cnt_d;
            asm_q       <= asm_d;
            busy        <= (state_d == SEND) || (state_d == WAIT_TX) || (state_d == RECV);
            instr_out   <= instr_d;
            instr_valid <= (state_d == DONE);
            fetch_err   <= (state_d == ERR);
            tx_start    <= (state_d == SEND);
            tx_data     <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_fetch_engine.sv
// Self-checking bench for uart_fetch_engine: vector table plus hand-written timeout,
// retry, reset and parameter-variant sequences, with tx/instr scoreboards.
module tb_uart_fetch_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        hold;
    logic [15:0] timeout_cycles;
    logic        busy;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        fetch_err;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        rx_done;
    logic [7:0]  rx_data;

    logic        v_fetch_req;
    logic [9:0]  v_fetch_addr;
    logic        v_busy;
    logic [11:0] v_instr_out;
    logic        v_instr_valid;
    logic        v_fetch_err;
    logic        v_tx_start;
    logic [7:0]  v_tx_data;
    logic        v_tx_done;
    logic        v_rx_done;
    logic [7:0]  v_rx_data;

    always #5 clk = ~clk;

    uart_fetch_engine dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .hold(hold), .timeout_cycles(timeout_cycles), .busy(busy), .instr_out(instr_out),
        .instr_valid(instr_valid), .fetch_err(fetch_err), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .rx_done(rx_done), .rx_data(rx_data)
    );

    uart_fetch_engine #(.ADDR_W(10), .INSTR_W(12), .HDR_EN(0)) dut_v (
        .clk(clk), .reset(reset), .fetch_req(v_fetch_req), .fetch_addr(v_fetch_addr),
        .hold(1'b0), .timeout_cycles(16'd0), .busy(v_busy), .instr_out(v_instr_out),
        .instr_valid(v_instr_valid), .fetch_err(v_fetch_err), .tx_start(v_tx_start),
        .tx_data(v_tx_data), .tx_done(v_tx_done), .rx_done(v_rx_done), .rx_data(v_rx_data)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  rx0;
        logic [7:0]  rx1;
        logic [15:0] exp;
        int          gap;
        bit          mid;
        bit          noise;
    } vec_t;

    vec_t        vecs [4];
    logic [7:0]  vexp [2];
    logic [7:0]  tx_q [$];
    logic [15:0] instr_q [$];
    int          gap_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tx_cd = 0;
    int          tx_done_cnt = 0;
    int          tx_start_cnt = 0;
    int          last_txd_cyc = 0;
    int          err_cnt = 0;
    bit          noise_en = 1'b0;
    logic [15:0] last_instr = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Host model: answers each tx_start with tx_done three cycles later and scores outputs.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tx_done = 1'b0;
            if (reset) begin
                tx_cd = 0;
            end else begin
                if (tx_cd != 0) begin
                    tx_cd--;
                    if (tx_cd == 0) begin
                        tx_done = 1'b1;
                        tx_done_cnt++;
                        last_txd_cyc = cyc;
                    end
                end
                if (tx_start) begin
                    tx_start_cnt++;
                    gap_q.push_back(cyc - last_txd_cyc);
                    chk("tx_start before previous tx_done", 32'(tx_cd != 0), 32'd0);
                    if (tx_q.size() == 0) begin
                        chk("unexpected tx_start data", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
                    end
                    tx_cd = 3;
                end
            end
            if (instr_valid) begin
                if (instr_q.size() == 0) begin
                    chk("unexpected instr_valid", 32'(instr_out), 32'hFFFF_FFFF);
                end else begin
                    chk("scoreboard instr_out", 32'(instr_out), 32'(instr_q.pop_front()));
                end
            end
            if (fetch_err) err_cnt++;
        end
    end

    task automatic wait_txd(input int target);
        int n;
        n = 0;
        while (tx_done_cnt < target && n < 500) begin
            rx_done = noise_en;
            rx_data = 8'hEE;
            tick;
            n++;
        end
        rx_done = 1'b0;
        chk("tx_done count reached", 32'(tx_done_cnt), 32'(target));
    endtask

    task automatic recv_bytes(input logic [7:0] b0, input logic [7:0] b1, input int gap);
        rx_data = b0;
        rx_done = 1'b1;
        tick;
        rx_done = 1'b0;
        repeat (gap) tick;
        rx_data = b1;
        rx_done = 1'b1;
        tick;
        rx_done = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] addr, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [15:0] exp, input int gap, input bit mid, input bit noise);
        int base;
        base = tx_done_cnt;
        tx_q.push_back(8'h03);
        tx_q.push_back(addr);
        instr_q.push_back(exp);
        noise_en = noise;
        fetch_addr = addr;
        fetch_req = 1'b1;
        tick;
        if (mid) fetch_addr = 8'h55;
        else fetch_req = 1'b0;
        wait_txd(base + 2);
        fetch_req = 1'b0;
        noise_en = 1'b0;
        recv_bytes(b0, b1, gap);
        chk("instr_valid after last byte", 32'(instr_valid), 32'd1);
        chk("busy low in done cycle", 32'(busy), 32'd0);
        chk("instr_out", 32'(instr_out), 32'(exp));
        tick;
        chk("instr_valid one cycle", 32'(instr_valid), 32'd0);
        repeat (5) tick;
        chk("tx queue drained", 32'(tx_q.size()), 32'd0);
        last_instr = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        vecs[0] = '{addr: 8'h2A, rx0: 8'h12, rx1: 8'h34, exp: 16'h1234, gap: 0, mid: 0, noise: 0};
        vecs[1] = '{addr: 8'hFF, rx0: 8'h00, rx1: 8'h01, exp: 16'h0001, gap: 3, mid: 0, noise: 1};
        vecs[2] = '{addr: 8'h00, rx0: 8'hFF, rx1: 8'hFF, exp: 16'hFFFF, gap: 0, mid: 1, noise: 0};
        vecs[3] = '{addr: 8'h80, rx0: 8'hA5, rx1: 8'h5A, exp: 16'hA55A, gap: 5, mid: 1, noise: 1};
        vexp[0] = 8'h03;
        vexp[1] = 8'hFF;

        reset = 1'b1;
        fetch_req = 1'b0;
        fetch_addr = 8'h0;
        hold = 1'b0;
        timeout_cycles = 16'd0;
        rx_done = 1'b0;
        rx_data = 8'h0;
        v_fetch_req = 1'b0;
        v_fetch_addr = 10'h0;
        v_tx_done = 1'b0;
        v_rx_done = 1'b0;
        v_rx_data = 8'h0;
        repeat (3) tick;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset instr_out", 32'(instr_out), 32'd0);
        chk("reset instr_valid", 32'(instr_valid), 32'd0);
        chk("reset fetch_err", 32'(fetch_err), 32'd0);
        chk("reset tx_start", 32'(tx_start), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        tick;

        // Vector table: basic fetches, rx noise during WAIT_TX, requests while busy.
        for (int i = 0; i < 4; i++) begin
            do_fetch(vecs[i].addr, vecs[i].rx0, vecs[i].rx1, vecs[i].exp,
                     vecs[i].gap, vecs[i].mid, vecs[i].noise);
        end

        // hold blocks acceptance.
        base = tx_start_cnt;
        fetch_addr = 8'h44;
        fetch_req = 1'b1;
        hold = 1'b1;
        repeat (10) tick;
        chk("hold: busy", 32'(busy), 32'd0);
        chk("hold: no tx_start", 32'(tx_start_cnt), 32'(base));
        fetch_req = 1'b0;
        tick;
        hold = 1'b0;

        // Timeout 100 with silent host: 3 retries then one fetch_err.
        timeout_cycles = 16'd100;
        gap_q.delete();
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(8'h03);
            tx_q.push_back(8'h2A);
        end
        base = err_cnt;
        fetch_addr = 8'h2A;
        fetch_req = 1'b1;
        tick;
        fetch_req = 1'b0;
        n = 0;
        while (err_cnt == base && n < 2000) begin
            tick;
            n++;
        end
        chk("fetch_err seen", 32'(err_cnt - base), 32'd1);
        chk("err busy", 32'(busy), 32'd0);
        chk("err instr_out unchanged", 32'(instr_out), 32'(last_instr));
        chk("err tx_start count", 32'(gap_q.size()), 32'd8);
        chk("in-frame tx gap", 32'(gap_q[1]), 32'd1);
        chk("retry 1 gap", 32'(gap_q[2]), 32'd102);
        chk("retry 2 gap", 32'(gap_q[4]), 32'd102);
        chk("retry 3 gap", 32'(gap_q[6]), 32'd102);
        repeat (5) tick;
        chk("fetch_err single pulse", 32'(err_cnt - base), 32'd1);
        chk("err tx queue drained", 32'(tx_q.size()), 32'd0);

        // Timeout disabled: no retransmit while waiting.
        timeout_cycles = 16'd0;
        base = tx_start_cnt;
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h2A);
        fetch_addr = 8'h2A;
        fetch_req = 1'b1;
        tick;
        fetch_req = 1'b0;
        wait_txd(tx_done_cnt + 2);
        repeat (10000) tick;
        chk("no-timeout tx_start count", 32'(tx_start_cnt - base), 32'd2);
        chk("no-timeout still busy", 32'(busy), 32'd1);
        instr_q.push_back(16'hBEEF);
        recv_bytes(8'hBE, 8'hEF, 0);
        chk("no-timeout instr_out", 32'(instr_out), 32'h0000_BEEF);
        last_instr = 16'hBEEF;
        tick;

        // Byte arriving exactly on the timeout cycle wins.
        timeout_cycles = 16'd20;
        do_fetch(8'h2A, 8'h12, 8'h34, 16'h1234, 20, 1'b0, 1'b1);

        // One cycle later the timeout fires and the late byte is dropped.
        base = tx_done_cnt;
        for (int i = 0; i < 2; i++) begin
            tx_q.push_back(8'h03);
            tx_q.push_back(8'h2A);
        end
        instr_q.push_back(16'h5678);
        fetch_addr = 8'h2A;
        fetch_req = 1'b1;
        tick;
        fetch_req = 1'b0;
        wait_txd(base + 2);
        recv_bytes(8'h12, 8'h34, 21);
        chk("late byte ignored", 32'(instr_valid), 32'd0);
        wait_txd(base + 4);
        recv_bytes(8'h56, 8'h78, 0);
        chk("retry instr_valid", 32'(instr_valid), 32'd1);
        chk("retry instr_out", 32'(instr_out), 32'h0000_5678);
        last_instr = 16'h5678;
        timeout_cycles = 16'd0;
        tick;

        // Reset in RECV after one byte.
        base = tx_done_cnt;
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h2A);
        fetch_addr = 8'h2A;
        fetch_req = 1'b1;
        tick;
        fetch_req = 1'b0;
        wait_txd(base + 2);
        rx_data = 8'h99;
        rx_done = 1'b1;
        tick;
        rx_done = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("reset in RECV busy", 32'(busy), 32'd0);
        chk("reset in RECV instr_out", 32'(instr_out), 32'd0);
        chk("reset in RECV tx_start", 32'(tx_start), 32'd0);
        last_instr = 16'h0;
        tick;
        do_fetch(8'h07, 8'h0A, 8'h0B, 16'h0A0B, 0, 1'b0, 1'b0);

        // 10-bit address, 12-bit instruction, no header.
        v_fetch_addr = 10'h3FF;
        v_fetch_req = 1'b1;
        tick;
        v_fetch_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!v_tx_start && n < 50) begin
                tick;
                n++;
            end
            chk("variant tx_start", 32'(v_tx_start), 32'd1);
            chk("variant tx_data", 32'(v_tx_data), 32'(vexp[k]));
            tick;
            tick;
            v_tx_done = 1'b1;
            tick;
            v_tx_done = 1'b0;
        end
        v_rx_data = 8'hAB;
        v_rx_done = 1'b1;
        tick;
        v_rx_data = 8'hCD;
        tick;
        v_rx_done = 1'b0;
        chk("variant instr_valid", 32'(v_instr_valid), 32'd1);
        chk("variant instr_out", 32'(v_instr_out), 32'h0000_0BCD);
        chk("variant busy", 32'(v_busy), 32'd0);
        chk("variant fetch_err", 32'(v_fetch_err), 32'd0);
        repeat (3) tick;
        chk("final instr queue drained", 32'(instr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
